multi_event_counter: RTL and testbench

//  N-channel programmable event counter/divider for the control datapath.

---
 rtl/multi_event_counter.sv | 127 ++++++++++++
 tb/tb_multi_event_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_event_counter.sv
// rtl/multi_event_counter.sv - N-channel programmable event counter/divider
//
// Purpose:
//   Each channel counts qualified events up to a runtime-programmable terminal
//   value and emits a registered one-cycle tick when the terminal is reached.
//   Each channel can be periodic or one-shot, and can count either high cycles
//   (level mode) or rising edges (edge mode).
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst          synchronous active-high reset
//   cfg_load     per-channel latch of cfg_term/cfg_oneshot/cfg_edge
//   cfg_term     per-channel terminal values, channel i at [i*CW +: CW]
//   cfg_oneshot  1 = one-shot, 0 = periodic
//   cfg_edge     1 = count rising edges, 0 = count high cycles
//   enable       per-channel count enable
//   clear        per-channel synchronous clear of count/done
//   event_in     raw event inputs
//   tick_out     one-cycle pulse when a channel reaches its terminal
//   done         one-shot sticky completion flag
//   count_out    current count per channel, channel i at [i*CW +: CW]

module multi_event_counter #(
  parameter int CHANNELS     = 4,
  parameter int COUNT_WIDTH  = 8,
  parameter int DEFAULT_TERM = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             cfg_load,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] cfg_term,
  input  logic [CHANNELS-1:0]             cfg_oneshot,
  input  logic [CHANNELS-1:0]             cfg_edge,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [CHANNELS-1:0]             clear,
  input  logic [CHANNELS-1:0]             event_in,
  output logic [CHANNELS-1:0]             tick_out,
  output logic [CHANNELS-1:0]             done,
  output logic [CHANNELS*COUNT_WIDTH-1:0] count_out
);

  localparam int CW = COUNT_WIDTH;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] term_q, term_d;
    logic          oneshot_q, oneshot_d;
    logic          edge_q, edge_d;
    logic          hist_q, hist_d;
    logic          done_q, done_d;
    logic          tick_q, tick_d;

    // One bit wider than the counter so term = 2**CW-1 compares without wrap.
    logic [CW:0]   eff_term;
    logic [CW:0]   count_inc;
    logic          qual_event;

    always_comb begin
      count_d   = count_q;
      term_d    = term_q;
      oneshot_d = oneshot_q;
      edge_d    = edge_q;
      done_d    = done_q;
      tick_d    = 1'b0;
      // History follows the raw input every cycle, independent of enable/clear/done.
      hist_d    = event_in[i];

      // A terminal of zero behaves like one: every event ticks.
      eff_term  = (term_q == '0) ? (CW+1)'(1) : {1'b0, term_q};
      count_inc = {1'b0, count_q} + (CW+1)'(1);

      qual_event = enable[i] & ~done_q &
                   (edge_q ? (event_in[i] & ~hist_q) : event_in[i]);

      if (cfg_load[i]) begin
        term_d    = cfg_term[i*CW +: CW];
        oneshot_d = cfg_oneshot[i];
        edge_d    = cfg_edge[i];
        count_d   = '0;
        done_d    = 1'b0;
      end else if (clear[i]) begin
        count_d = '0;
        done_d  = 1'b0;
      end else if (qual_event) begin
        if (count_inc >= eff_term) begin
          tick_d = 1'b1;
          if (oneshot_q) begin
            // One-shot parks at its terminal; done blocks further events.
            count_d = eff_term[CW-1:0];
            done_d  = 1'b1;
          end else begin
            count_d = '0;
          end
        end else begin
          count_d = count_inc[CW-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q   <= '0;
        term_q    <= CW'(DEFAULT_TERM);
        oneshot_q <= 1'b0;
        edge_q    <= 1'b0;
        hist_q    <= 1'b0;
        done_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        count_q   <= count_d;
        term_q    <= term_d;
        oneshot_q <= oneshot_d;
        edge_q    <= edge_d;
        hist_q    <= hist_d;
        done_q    <= done_d;
        tick_q    <= tick_d;
      end
    end

    assign tick_out[i]            = tick_q;
    assign done[i]                = done_q;
    assign count_out[i*CW +: CW]  = count_q;

  end : g_ch

endmodule

// File: tb/tb_multi_event_counter.sv
// tb/tb_multi_event_counter.sv - self-checking bench for multi_event_counter

module tb_multi_event_counter;

  localparam int CH = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    cfg_load, cfg_oneshot, cfg_edge, enable, clear, event_in;
  logic [CH*CW-1:0] cfg_term;
  logic [CH-1:0]    tick_out, done;
  logic [CH*CW-1:0] count_out;

  always #5 clk = ~clk;

  multi_event_counter #(
    .CHANNELS    (CH),
    .COUNT_WIDTH (CW),
    .DEFAULT_TERM(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_term   (cfg_term),
    .cfg_oneshot(cfg_oneshot),
    .cfg_edge   (cfg_edge),
    .enable     (enable),
    .clear      (clear),
    .event_in   (event_in),
    .tick_out   (tick_out),
    .done       (done),
    .count_out  (count_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one entry per channel.
  int m_count[CH];
  int m_term[CH];
  bit m_one[CH], m_edge[CH], m_hist[CH], m_done[CH], m_tick[CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      bit ev, qual;
      int eff;
      ev = event_in[c];
      if (rst) begin
        m_count[c] = 0; m_tick[c] = 0; m_done[c] = 0; m_term[c] = 3;
        m_one[c] = 0; m_edge[c] = 0; m_hist[c] = 0;
        continue;
      end
      qual = enable[c] && !m_done[c] && (m_edge[c] ? (ev && !m_hist[c]) : ev);
      m_hist[c] = ev;
      m_tick[c] = 0;
      if (cfg_load[c]) begin
        m_term[c] = int'(cfg_term[c*CW +: CW]);
        m_one[c] = cfg_oneshot[c];
        m_edge[c] = cfg_edge[c];
        m_count[c] = 0;
        m_done[c] = 0;
      end else if (clear[c]) begin
        m_count[c] = 0;
        m_done[c] = 0;
      end else if (qual) begin
        eff = (m_term[c] == 0) ? 1 : m_term[c];
        if (m_count[c] + 1 == eff) begin
          m_tick[c] = 1;
          if (m_one[c]) begin
            m_count[c] = eff;
            m_done[c] = 1;
          end else begin
            m_count[c] = 0;
          end
        end else begin
          m_count[c] = m_count[c] + 1;
        end
      end
    end
  endfunction

  task automatic step(input int n = 1);
    logic [CH-1:0]    e_tick, e_done;
    logic [CH*CW-1:0] e_cnt;
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < CH; c++) begin
        e_tick[c] = m_tick[c];
        e_done[c] = m_done[c];
        e_cnt[c*CW +: CW] = CW'(m_count[c]);
      end
      check("model_tick", 64'(tick_out), 64'(e_tick));
      check("model_done", 64'(done), 64'(e_done));
      check("model_count", 64'(count_out), 64'(e_cnt));
    end
  endtask

  task automatic load(input int ch, input int term, input bit one, input bit edg);
    cfg_load = '0;
    cfg_load[ch] = 1'b1;
    cfg_term[ch*CW +: CW] = CW'(term);
    cfg_oneshot[ch] = one;
    cfg_edge[ch] = edg;
    step();
    cfg_load = '0;
  endtask

  int t1_cnt[7]  = '{1, 2, 0, 1, 2, 0, 1};
  int t1_tick[7] = '{0, 0, 1, 0, 0, 1, 0};
  int ticks;

  initial begin
    rst = 1'b1;
    cfg_load = '0; cfg_term = '0; cfg_oneshot = '0; cfg_edge = '0;
    enable = '0; clear = '0; event_in = '0;
    step(2);
    check("rst_count", 64'(count_out), 64'd0);
    check("rst_tick", 64'(tick_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Level mode, default terminal 3.
    enable[0] = 1'b1; event_in[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t1_count", 64'(count_out[CW-1:0]), 64'(t1_cnt[k]));
      check("t1_tick", 64'(tick_out[0]), 64'(t1_tick[k]));
    end
    enable[0] = 1'b0; event_in[0] = 1'b0;

    // Edge mode, terminal 2: held high counts once, then three pulses.
    load(1, 2, 1'b0, 1'b1);
    enable[1] = 1'b1; event_in[1] = 1'b1;
    step(5);
    check("t2_held_count", 64'(count_out[2*CW-1:CW]), 64'd1);
    ticks = 0;
    repeat (3) begin
      event_in[1] = 1'b0; step(); ticks += int'(tick_out[1]);
      event_in[1] = 1'b1; step(); ticks += int'(tick_out[1]);
    end
    check("t2_ticks", 64'(ticks), 64'd2);
    enable[1] = 1'b0; event_in[1] = 1'b0;

    // One-shot, terminal 4.
    load(2, 4, 1'b1, 1'b0);
    enable[2] = 1'b1; event_in[2] = 1'b1; ticks = 0;
    repeat (6) begin step(); ticks += int'(tick_out[2]); end
    check("t3_ticks", 64'(ticks), 64'd1);
    check("t3_done", 64'(done[2]), 64'd1);
    check("t3_count", 64'(count_out[3*CW-1:2*CW]), 64'd4);
    event_in[2] = 1'b0; clear[2] = 1'b1; step(); clear[2] = 1'b0;
    check("t3_clr_count", 64'(count_out[3*CW-1:2*CW]), 64'd0);
    check("t3_clr_done", 64'(done[2]), 64'd0);
    event_in[2] = 1'b1; ticks = 0;
    repeat (4) begin step(); ticks += int'(tick_out[2]); end
    check("t3_reticks", 64'(ticks), 64'd1);
    enable[2] = 1'b0; event_in[2] = 1'b0;

    // Terminal 0 ticks on every event; terminal 255 reaches 255 without wrap.
    load(3, 0, 1'b0, 1'b0);
    enable[3] = 1'b1; event_in[3] = 1'b1; ticks = 0;
    repeat (5) begin step(); ticks += int'(tick_out[3]); end
    check("t4_term0_ticks", 64'(ticks), 64'd5);
    load(3, 255, 1'b0, 1'b0);
    ticks = 0;
    repeat (254) begin step(); ticks += int'(tick_out[3]); end
    check("t4_254_count", 64'(count_out[4*CW-1:3*CW]), 64'd254);
    check("t4_254_ticks", 64'(ticks), 64'd0);
    step();
    check("t4_255_tick", 64'(tick_out[3]), 64'd1);
    check("t4_255_count", 64'(count_out[4*CW-1:3*CW]), 64'd0);
    event_in[3] = 1'b0;

    // Same-cycle clear/load drop the event; reset mid-count.
    enable[0] = 1'b1; event_in[0] = 1'b1;
    step();
    clear[0] = 1'b1; step(); clear[0] = 1'b0;
    check("t5_clr_count", 64'(count_out[CW-1:0]), 64'd0);
    check("t5_clr_tick", 64'(tick_out[0]), 64'd0);
    step();
    load(0, 3, 1'b0, 1'b0);
    check("t5_load_count", 64'(count_out[CW-1:0]), 64'd0);
    check("t5_load_tick", 64'(tick_out[0]), 64'd0);
    step(2);
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_rst_count", 64'(count_out), 64'd0);
    check("t5_rst_tick", 64'(tick_out), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);

    // All channels at terminal 1, ticking together.
    cfg_load = '1; cfg_oneshot = '0; cfg_edge = '0;
    for (int c = 0; c < CH; c++) cfg_term[c*CW +: CW] = CW'(1);
    step(); cfg_load = '0;
    enable = '1; event_in = '1;
    repeat (3) begin
      step();
      check("t6_all_tick", 64'(tick_out), 64'hF);
    end
    enable[3] = 1'b0;
    step();
    check("t6_ch3_off", 64'(tick_out), 64'h7);
    check("t6_ch3_count", 64'(count_out[4*CW-1:3*CW]), 64'd0);

    // Randomized traffic against the model.
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < CH; c++) begin
        cfg_load[c]    = ($urandom_range(0, 39) == 0);
        clear[c]       = ($urandom_range(0, 49) == 0);
        enable[c]      = ($urandom_range(0, 3) != 0);
        event_in[c]    = 1'($urandom_range(0, 1));
        cfg_oneshot[c] = 1'($urandom_range(0, 1));
        cfg_edge[c]    = 1'($urandom_range(0, 1));
        cfg_term[c*CW +: CW] = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255))
                                                           : CW'($urandom_range(0, 5));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
